// File: rtl/cprv_pkg.sv
// Shared definitions for the cprv pipeline front end.
//   - default instruction/address widths (shared with cprv_id_stage)
//   - default reset PC and fetch buffer depth
//   - if_state_t : fetch stage control states
package cprv_pkg;

  localparam int          CPRV_INSTR_WIDTH = 32;
  localparam int          CPRV_ADDR_WIDTH  = 64;
  localparam logic [63:0] CPRV_RESET_PC    = 64'h0;
  localparam int          CPRV_FIFO_DEPTH  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } if_state_t;

endpackage

// File: rtl/cprv_fetch_fifo.sv
// Small instruction buffer between instruction memory and the ID stage.
// Entries hold {pc, instr}. Storage is registered, so a push becomes visible
// at the head on the following cycle. Flush beats push; pop of an empty
// buffer is ignored.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data at the tail
//   push_data    entry to write
//   pop          remove the head entry
//   flush        discard all entries (wins over push)
//   head_data    head entry, zero while empty
//   count        number of valid entries
//   empty, full  occupancy flags
module cprv_fetch_fifo
  import cprv_pkg::*;
#(
  parameter  int DEPTH = CPRV_FIFO_DEPTH,
  parameter  int WIDTH = CPRV_ADDR_WIDTH + CPRV_INSTR_WIDTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [DEPTH-1:0] wr_en;
  logic             do_push, do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;

  // One write-enable per entry, selected by the tail pointer.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && (wr_ptr_reg == PW'(gi));
  end

  // Data storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem_reg[i] <= push_data;
    end
  end

  // Pointers are log2(DEPTH) wide and wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_data = empty ? '0 : mem_reg[rd_ptr_reg];

  // The fetch credit scheme must make this impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
                                   !(push && !flush && full && !pop));

endmodule

// File: rtl/cprv_if_stage.sv
// Instruction fetch stage. Owns the PC, issues in-order word fetches,
// buffers returned instructions and hands them to ID over valid/ready.
// A redirect flushes buffered instructions; responses to fetches still in
// flight at that moment are counted and discarded in DRAIN.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req_o        fetch request (may drop without a grant)
//   imem_addr_o       fetch address (current pc)
//   imem_gnt_i        request accepted this cycle
//   imem_rvalid_i     in-order response valid (latency >= 1)
//   imem_rdata_i      response instruction
//   redirect_i        flush and restart at redirect_pc_i
//   redirect_pc_i     new pc (word aligned)
//   valid_id_o        head instruction valid toward ID
//   ready_id_i        ID accepts the head
//   instr_data_id_o   head instruction
//   pc_id_o           pc of the head instruction
module cprv_if_stage
  import cprv_pkg::*;
#(
  parameter int                    INSTR_WIDTH = CPRV_INSTR_WIDTH,
  parameter int                    ADDR_WIDTH  = CPRV_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(CPRV_RESET_PC),
  parameter int                    FIFO_DEPTH  = CPRV_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  output logic                   valid_id_o,
  input  logic                   ready_id_i,
  output logic [INSTR_WIDTH-1:0] instr_data_id_o,
  output logic [ADDR_WIDTH-1:0]  pc_id_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = ADDR_WIDTH + INSTR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] WORD = ADDR_WIDTH'(4);

  if_state_t             state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0] resp_pc_reg, resp_pc_next;
  logic [CW-1:0]         outstanding_reg, outstanding_next;
  logic [CW-1:0]         drop_cnt_reg, drop_cnt_next;

  logic          fifo_push, fifo_flush, fifo_pop;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] fifo_head;
  logic          credit_ok, fetch_fire, redirect_take;
  logic [CW:0]   in_use;
  logic [CW-1:0] stale_left;

  // Credit counts both in-flight and buffered fetches, using registered
  // values only, so a pop this cycle frees a slot from the next cycle.
  assign in_use     = {1'b0, outstanding_reg} + {1'b0, fifo_count};
  assign credit_ok  = !fifo_full && (in_use < (CW + 1)'(FIFO_DEPTH));
  assign imem_req_o = (state_reg == FETCH) && !redirect_i && credit_ok;
  assign imem_addr_o = pc_reg;
  assign fetch_fire = imem_req_o && imem_gnt_i;

  assign redirect_take = redirect_i && (state_reg != IDLE);
  // A response arriving with the redirect is consumed now, not dropped later.
  assign stale_left    = outstanding_reg - CW'(imem_rvalid_i);

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg;
    drop_cnt_next    = drop_cnt_reg;
    fifo_push        = 1'b0;
    fifo_flush       = 1'b0;

    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (imem_rvalid_i) begin
          fifo_push    = 1'b1;
          resp_pc_next = resp_pc_reg + WORD;
        end
        if (fetch_fire) pc_next = pc_reg + WORD;
        outstanding_next = outstanding_reg + CW'(fetch_fire) - CW'(imem_rvalid_i);
      end
      DRAIN: begin
        if (imem_rvalid_i) begin
          drop_cnt_next    = drop_cnt_reg - CW'(1);
          outstanding_next = outstanding_reg - CW'(1);
        end
        if (drop_cnt_next == '0) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase

    // Redirect overrides everything above.
    if (redirect_take) begin
      fifo_flush       = 1'b1;
      pc_next          = redirect_pc_i;
      resp_pc_next     = redirect_pc_i;
      drop_cnt_next    = stale_left;
      outstanding_next = stale_left;
      state_next       = (stale_left != '0) ? DRAIN : FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  assign fifo_pop = valid_id_o && ready_id_i;

  cprv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({resp_pc_reg, imem_rdata_i}),
    .pop       (fifo_pop),
    .flush     (fifo_flush),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign valid_id_o                 = !fifo_empty;
  assign {pc_id_o, instr_data_id_o} = fifo_head;

endmodule
